mem_load_return: RTL and testbench

Load-return unit: receives read data for a load already issued against memory and produces the register writeback value. It selects the byte lane (big-endian: address offset 0 maps to bits [31:24]) and sign- or zero-extends, and merges LWL/LWR partial words with the old rt value. It sits at the MEM/WB boundary as the read-side counterpart of the ID-stage address/byte-select processor. It tracks exactly one outstanding load, with flush draining and a response watchdog.

---
 rtl/mem_load_return_pkg.sv | 40 ++++
 rtl/mem_load_return_align.sv | 74 +++++++
 rtl/mem_load_return.sv | 146 ++++++++++++++
 tb/tb_mem_load_return.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_load_return_pkg.sv
// Shared definitions for the load-return unit: opcodes, FSM states, counter width.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package mem_load_return_pkg;

    // Load opcodes (MIPS primary opcode field)
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_LL  = 6'h30;

    // Response watchdog counter width; timeout limit must fit in it
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // True for every opcode this unit will issue a read for
    function automatic logic is_load_op(input logic [5:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL: r = 1'b1;
`ifdef LOAD_RETURN_LWLR_EN
            OP_LWL, OP_LWR: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_load_return_align.sv
// Load data aligner: big-endian lane select, sign/zero extend, LWL/LWR merge with rt.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_data_align
    import mem_load_return_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_rt,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane pick: offset 0 is the most significant byte
    always_comb begin
        w_byte = i_rdata[31:24];
        case (i_off)
            2'd0: w_byte = i_rdata[31:24];
            2'd1: w_byte = i_rdata[23:16];
            2'd2: w_byte = i_rdata[15:8];
            2'd3: w_byte = i_rdata[7:0];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    // Halfword pick: only the upper offset bit matters for aligned halves
    always_comb begin
        w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];
    end

`ifndef LOAD_RETURN_LWLR_EN
    // rt is only a merge base for partial-word loads, which are absent here
    logic w_unused_rt;
    assign w_unused_rt = ^i_rt;
`endif

    // Final result selection by opcode
    always_comb begin
        o_result = i_rdata;
        case (i_op)
            OP_LB:  o_result = {{24{w_byte[7]}}, w_byte};
            OP_LBU: o_result = {24'd0, w_byte};
            OP_LH:  o_result = {{16{w_half[15]}}, w_half};
            OP_LHU: o_result = {16'd0, w_half};
            OP_LW,
            OP_LL:  o_result = i_rdata;
`ifdef LOAD_RETURN_LWLR_EN
            OP_LWL: begin
                case (i_off)
                    2'd0: o_result = i_rdata;
                    2'd1: o_result = {i_rdata[23:0], i_rt[7:0]};
                    2'd2: o_result = {i_rdata[15:0], i_rt[15:0]};
                    2'd3: o_result = {i_rdata[7:0],  i_rt[23:0]};
                    default: o_result = i_rdata;
                endcase
            end
            OP_LWR: begin
                case (i_off)
                    2'd0: o_result = {i_rt[31:8],  i_rdata[31:24]};
                    2'd1: o_result = {i_rt[31:16], i_rdata[31:16]};
                    2'd2: o_result = {i_rt[31:24], i_rdata[31:8]};
                    2'd3: o_result = i_rdata;
                    default: o_result = i_rdata;
                endcase
            end
`endif
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_load_return.sv
// Load-return unit: one outstanding load, flush drain, response watchdog, registered writeback.
// Latency: issue N -> read request N+1; earliest writeback N+2 (rvalid in the request cycle).
// Backpressure: o_busy stalls the pipeline while a request is outstanding. LWL/LWR need LOAD_RETURN_LWLR_EN.
module mem_load_return
    import mem_load_return_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_issue,
    input  logic [5:0]  i_instr_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rt_value,
    input  logic [4:0]  i_dest_reg,
    input  logic        i_flush,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mem_rd_req,
    output logic        o_busy,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_reg,
    output logic [31:0] o_wb_data,
    output logic        o_bus_err
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_op;
    logic [1:0]       r_off;
    logic [4:0]       r_dest;
    logic [31:0]      w_rt_base;
    logic [31:0]      w_result;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_timeout;
    logic             w_accept;

`ifdef LOAD_RETURN_LWLR_EN
    logic [31:0] r_rt;

    // Capture rt at accept so the merge uses the value seen at issue time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rt <= 32'd0;
        end else if (w_accept && (r_state == ST_IDLE || r_state == ST_RESP)) begin
            r_rt <= i_rt_value;
        end
    end

    assign w_rt_base = r_rt;
`else
    // Without partial-word loads there is nothing to merge with
    logic w_unused_rt;
    assign w_unused_rt = ^i_rt_value;
    assign w_rt_base   = 32'd0;
`endif

    assign w_accept   = i_issue && is_load_op(i_instr_op) && !i_flush;
    assign w_cnt_next = r_cnt + 1'b1;
    // The current cycle is the last allowed WAIT/DRAIN cycle
    assign w_timeout  = (w_cnt_next >= TO_LIM);

    load_data_align u_align (
        .i_op     (r_op),
        .i_off    (r_off),
        .i_rdata  (i_mem_rdata),
        .i_rt     (w_rt_base),
        .o_result (w_result)
    );

    // Single-process FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_op         <= 6'd0;
            r_off        <= 2'd0;
            r_dest       <= 5'd0;
            o_mem_rd_req <= 1'b0;
            o_busy       <= 1'b0;
            o_wb_valid   <= 1'b0;
            o_wb_reg     <= 5'd0;
            o_wb_data    <= 32'd0;
            o_bus_err    <= 1'b0;
        end else begin
            o_mem_rd_req <= 1'b0;
            o_wb_valid   <= 1'b0;
            o_bus_err    <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_accept) begin
                        r_op         <= i_instr_op;
                        r_off        <= i_addr_lo;
                        r_dest       <= i_dest_reg;
                        r_cnt        <= '0;
                        r_state      <= ST_WAIT;
                        o_mem_rd_req <= 1'b1;
                        o_busy       <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (i_flush) begin
                        // A response or timeout coinciding with the flush ends the load quietly
                        if (i_mem_rvalid || w_timeout) begin
                            r_state <= ST_IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_cnt   <= w_cnt_next;
                        end
                    end else if (i_mem_rvalid) begin
                        r_state    <= ST_RESP;
                        o_busy     <= 1'b0;
                        o_wb_valid <= 1'b1;
                        o_wb_reg   <= r_dest;
                        o_wb_data  <= w_result;
                    end else if (w_timeout) begin
                        r_state   <= ST_IDLE;
                        o_busy    <= 1'b0;
                        o_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                ST_DRAIN: begin
                    if (i_mem_rvalid || w_timeout) begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_return.sv
// Bench for mem_load_return: vector table, hand-written corner sequences, randomized loads vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_load_return;
    import mem_load_return_pkg::*;

    localparam int TO = 4;
`ifdef LOAD_RETURN_LWLR_EN
    localparam bit LWLR = 1'b1;
`else
    localparam bit LWLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_issue;
    logic [5:0]  i_instr_op;
    logic [1:0]  i_addr_lo;
    logic [31:0] i_rt_value;
    logic [4:0]  i_dest_reg;
    logic        i_flush;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_mem_rd_req;
    logic        o_busy;
    logic        o_wb_valid;
    logic [4:0]  o_wb_reg;
    logic [31:0] o_wb_data;
    logic        o_bus_err;

    int n_chk = 0;
    int n_err = 0;

    mem_load_return #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_issue      (i_issue),
        .i_instr_op   (i_instr_op),
        .i_addr_lo    (i_addr_lo),
        .i_rt_value   (i_rt_value),
        .i_dest_reg   (i_dest_reg),
        .i_flush      (i_flush),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_mem_rd_req (o_mem_rd_req),
        .o_busy       (o_busy),
        .o_wb_valid   (o_wb_valid),
        .o_wb_reg     (o_wb_reg),
        .o_wb_data    (o_wb_data),
        .o_bus_err    (o_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [1:0]  off;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic        acc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: partial-word loads as shifts of the word against the rt base
    function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [1:0] off,
                                               input logic [31:0] rt, input logic [31:0] rd);
        longint unsigned w, b, h, m;
        int o;
        o = int'(off);
        w = 64'(rd);
        b = (w >> (8 * (3 - o))) & 64'hFF;
        h = (w >> (o >= 2 ? 0 : 16)) & 64'hFFFF;
        case (op)
            OP_LB:  return (b >= 64'h80) ? 32'(b + 64'hFFFFFF00) : 32'(b);
            OP_LBU: return 32'(b);
            OP_LH:  return (h >= 64'h8000) ? 32'(h + 64'hFFFF0000) : 32'(h);
            OP_LHU: return 32'(h);
            OP_LWL: begin
                m = (64'd1 << (8 * o)) - 1;
                return 32'((w << (8 * o)) | (64'(rt) & m));
            end
            OP_LWR: begin
                m = (64'd1 << (8 * (o + 1))) - 1;
                return 32'((w >> (8 * (3 - o))) | (64'(rt) & ~m));
            end
            default: return rd;
        endcase
    endfunction

    function automatic bit model_accepts(input logic [5:0] op);
        if (op == OP_LWL || op == OP_LWR) return LWLR;
        return (op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU ||
                op == OP_LW || op == OP_LL);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops[9];
        rst = 1'b1; i_issue = 1'b0; i_instr_op = 6'd0; i_addr_lo = 2'd0; i_rt_value = 32'd0;
        i_dest_reg = 5'd0; i_flush = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;

        vecs[0]  = '{OP_LB,  2'd1, 32'h0,        32'h12F45678, 1'b1, 32'hFFFFFFF4};
        vecs[1]  = '{OP_LBU, 2'd1, 32'h0,        32'h12F45678, 1'b1, 32'h000000F4};
        vecs[2]  = '{OP_LH,  2'd2, 32'h0,        32'h12348001, 1'b1, 32'hFFFF8001};
        vecs[3]  = '{OP_LHU, 2'd0, 32'h0,        32'h12348001, 1'b1, 32'h00001234};
        vecs[4]  = '{OP_LWL, 2'd1, 32'hAABBCCDD, 32'h11223344, LWLR, 32'h223344DD};
        vecs[5]  = '{OP_LWR, 2'd1, 32'hAABBCCDD, 32'h11223344, LWLR, 32'hAABB1122};
        vecs[6]  = '{OP_LW,  2'd0, 32'h0,        32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        vecs[7]  = '{OP_LB,  2'd3, 32'h0,        32'h12F45680, 1'b1, 32'hFFFFFF80};
        vecs[8]  = '{OP_LBU, 2'd0, 32'h0,        32'h92F45678, 1'b1, 32'h00000092};
        vecs[9]  = '{OP_LWL, 2'd3, 32'hAABBCCDD, 32'h11223344, LWLR, 32'h44BBCCDD};
        vecs[10] = '{OP_LWR, 2'd0, 32'hAABBCCDD, 32'h11223344, LWLR, 32'hAABBCC11};
        vecs[11] = '{6'h2B,  2'd0, 32'h0,        32'h11223344, 1'b0, 32'h0};

        // Reset state
        step(); step();
        chk("rst_rd_req", 32'(o_mem_rd_req), 32'd0);
        chk("rst_busy",   32'(o_busy),       32'd0);
        chk("rst_wb_vld", 32'(o_wb_valid),   32'd0);
        chk("rst_wb_reg", 32'(o_wb_reg),     32'd0);
        chk("rst_wb_dat", o_wb_data,         32'd0);
        chk("rst_bus_err", 32'(o_bus_err),   32'd0);
        rst = 1'b0;
        step();

        // Vector table: rvalid arrives in the request cycle
        for (int i = 0; i < 12; i++) begin
            i_issue = 1'b1; i_instr_op = vecs[i].op; i_addr_lo = vecs[i].off;
            i_rt_value = vecs[i].rt; i_dest_reg = 5'(i + 1);
            step();
            chk($sformatf("vec%0d_rd_req", i), 32'(o_mem_rd_req), 32'(vecs[i].acc));
            chk($sformatf("vec%0d_busy", i),   32'(o_busy),       32'(vecs[i].acc));
            i_issue = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = vecs[i].rdata;
            step();
            i_mem_rvalid = 1'b0;
            chk($sformatf("vec%0d_wb_vld", i), 32'(o_wb_valid), 32'(vecs[i].acc));
            if (vecs[i].acc) begin
                chk($sformatf("vec%0d_wb_dat", i), o_wb_data,      vecs[i].exp);
                chk($sformatf("vec%0d_wb_reg", i), 32'(o_wb_reg),  32'(i + 1));
            end
            step();
            chk($sformatf("vec%0d_wb_once", i), 32'(o_wb_valid), 32'd0);
        end

        // Flush one cycle after issue, rvalid three cycles after issue
        i_issue = 1'b1; i_instr_op = OP_LW; i_addr_lo = 2'd0; i_dest_reg = 5'd7;
        step();                                 // N+1
        i_issue = 1'b0; i_flush = 1'b1;
        chk("fl_busy1", 32'(o_busy), 32'd1);
        step();                                 // N+2
        i_flush = 1'b0;
        chk("fl_busy2", 32'(o_busy), 32'd1);
        step();                                 // N+3
        chk("fl_busy3", 32'(o_busy), 32'd1);
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h55555555;
        step();                                 // N+4
        i_mem_rvalid = 1'b0;
        chk("fl_wb_vld", 32'(o_wb_valid), 32'd0);
        chk("fl_idle",   32'(o_busy),     32'd0);
        chk("fl_no_err", 32'(o_bus_err),  32'd0);
        step();
        chk("fl_wb_vld2", 32'(o_wb_valid), 32'd0);

        // Timeout with no response, then a late rvalid
        i_issue = 1'b1; i_instr_op = OP_LW; i_dest_reg = 5'd3;
        step();
        i_issue = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            chk($sformatf("to_busy_c%0d", k), 32'(o_busy),    32'd1);
            chk($sformatf("to_err_c%0d", k),  32'(o_bus_err), 32'd0);
            step();
        end
        chk("to_err_pulse", 32'(o_bus_err), 32'd1);
        chk("to_idle",      32'(o_busy),    32'd0);
        i_mem_rvalid = 1'b1;
        step();
        i_mem_rvalid = 1'b0;
        chk("to_err_once", 32'(o_bus_err), 32'd0);
        step();
        chk("to_late_wb", 32'(o_wb_valid), 32'd0);

        // Back-to-back: second LW accepted in the RESP cycle
        i_issue = 1'b1; i_instr_op = OP_LW; i_dest_reg = 5'd5;
        step();                                 // N+1
        i_issue = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hA5A5A5A5;
        step();                                 // N+2 (RESP)
        i_mem_rvalid = 1'b0;
        chk("b2b_wb1_vld", 32'(o_wb_valid), 32'd1);
        chk("b2b_wb1_reg", 32'(o_wb_reg),   32'd5);
        chk("b2b_wb1_dat", o_wb_data,       32'hA5A5A5A5);
        i_issue = 1'b1; i_instr_op = OP_LW; i_dest_reg = 5'd9;
        step();                                 // N+3
        i_issue = 1'b0;
        chk("b2b_rd_req2", 32'(o_mem_rd_req), 32'd1);
        chk("b2b_hold_dat", o_wb_data,        32'hA5A5A5A5);
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h3C3C3C3C;
        step();                                 // N+4
        i_mem_rvalid = 1'b0;
        chk("b2b_wb2_vld", 32'(o_wb_valid), 32'd1);
        chk("b2b_wb2_reg", 32'(o_wb_reg),   32'd9);
        chk("b2b_wb2_dat", o_wb_data,       32'h3C3C3C3C);
        step();

        // Reset in the middle of WAIT; a later rvalid must be ignored
        i_issue = 1'b1; i_instr_op = OP_LW; i_dest_reg = 5'd11;
        step();
        i_issue = 1'b0;
        chk("rw_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_busy_rst", 32'(o_busy), 32'd0);
        #1 rst = 1'b0;
        step();
        i_mem_rvalid = 1'b1;
        step();
        i_mem_rvalid = 1'b0;
        chk("rw_no_wb", 32'(o_wb_valid), 32'd0);
        step();

        // Randomized loads with variable response delay
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_LWL, OP_LWR, 6'h2B};
        for (int it = 0; it < 150; it++) begin
            logic [5:0]  op;
            logic [1:0]  off;
            logic [31:0] rt, rd;
            logic [4:0]  dst;
            int d, wb_cyc, err_cyc, exp_wb, exp_err;
            logic rreq, acc;
            logic [31:0] got_dat;
            logic [4:0]  got_reg;
            op  = ops[$urandom_range(0, 8)];
            off = 2'($urandom_range(0, 3));
            rt  = $urandom;
            rd  = $urandom;
            dst = 5'($urandom_range(0, 31));
            d   = $urandom_range(0, 5);
            acc = model_accepts(op);
            wb_cyc = -1; err_cyc = -1; rreq = 1'b0; got_dat = 32'd0; got_reg = 5'd0;

            i_issue = 1'b1; i_instr_op = op; i_addr_lo = off; i_rt_value = rt; i_dest_reg = dst;
            step();
            i_issue = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                i_mem_rvalid = (k == d + 1);
                i_mem_rdata  = rd;
                if (k == 1) rreq = o_mem_rd_req;
                if (o_wb_valid && wb_cyc < 0) begin
                    wb_cyc = k; got_dat = o_wb_data; got_reg = o_wb_reg;
                end
                if (o_bus_err && err_cyc < 0) err_cyc = k;
                step();
            end
            i_mem_rvalid = 1'b0;

            exp_wb  = (acc && d < TO) ? d + 2 : -1;
            exp_err = (acc && d >= TO) ? TO + 1 : -1;
            chk($sformatf("rnd%0d_rd_req", it), 32'(rreq),    32'(acc));
            chk($sformatf("rnd%0d_wb_cyc", it), 32'(wb_cyc),  32'(exp_wb));
            chk($sformatf("rnd%0d_err_cyc", it), 32'(err_cyc), 32'(exp_err));
            if (exp_wb > 0) begin
                chk($sformatf("rnd%0d_wb_dat", it), got_dat,       ref_result(op, off, rt, rd));
                chk($sformatf("rnd%0d_wb_reg", it), 32'(got_reg),  32'(dst));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
